// File: rtl/async_dual_port_ram.sv
`default_nettype none
// ============================================================================
// Module      : async_dual_port_ram
// Description : Simple dual-port RAM with one write port and one read port,
//               each with its own address, on a single clock. Reads are
//               registered (1-cycle latency). A read and a write to the same
//               address on the same edge return the new write data.
//               rst is asynchronous and active-high. It clears the outputs
//               at once and clears the whole array while it is held.
// Revision    : 1.0 - initial release
// ============================================================================
module async_dual_port_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_en,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_data_out,
    output logic                  o_rd_valid
);

    localparam int c_DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_rd_valid;
    logic                  w_collision;

    // A same-address read and write on one edge forwards the write data.
    assign w_collision = i_wr_en && i_rd_en && (i_wr_addr == i_rd_addr);

    // Storage array: cleared while rst is held, otherwise written on wr_en.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Registered read port: data holds when idle, and valid pulses once per read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data_out <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= i_rd_en;
            if (i_rd_en) begin
                r_data_out <= w_collision ? i_wr_data : r_mem[i_rd_addr];
            end
        end
    end

    assign o_data_out = r_data_out;
    assign o_rd_valid = r_rd_valid;

endmodule
`default_nettype wire

// File: tb/tb_async_dual_port_ram.sv
`default_nettype none
// ============================================================================
// Module      : tb_async_dual_port_ram
// Description : Directed self-checking bench for async_dual_port_ram
//               (16 x 8 default configuration).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_async_dual_port_ram;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       rd_en;
    logic [3:0] rd_addr;
    logic [7:0] data_out;
    logic       rd_valid;

    int n_pass  = 0;
    int n_total = 0;

    async_dual_port_ram #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (wr_en),
        .i_wr_addr (wr_addr),
        .i_wr_data (wr_data),
        .i_rd_en   (rd_en),
        .i_rd_addr (rd_addr),
        .o_data_out(data_out),
        .o_rd_valid(rd_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    initial begin
        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        rd_en   = 1'b0;
        rd_addr = '0;

        // Reset held for two edges.
        step();
        step();
        check("reset_data", data_out, 8'h00);
        check("reset_valid", {7'd0, rd_valid}, 8'h01 & 8'h00);
        rst = 1'b0;

        // Read back every location after reset.
        for (int i = 0; i < 16; i++) begin
            rd_en   = 1'b1;
            rd_addr = 4'(i);
            step();
            check($sformatf("rst_read_data[%0d]", i), data_out, 8'h00);
            check($sformatf("rst_read_valid[%0d]", i), {7'd0, rd_valid}, 8'h01);
        end
        rd_en = 1'b0;
        step();
        check("rst_read_valid_drop", {7'd0, rd_valid}, 8'h00);

        // Sequential writes of 0xA0+i.
        for (int i = 0; i < 8; i++) begin
            wr_en   = 1'b1;
            wr_addr = 4'(i);
            wr_data = 8'(8'hA0 + i);
            step();
        end
        wr_en = 1'b0;

        // Sequential reads.
        for (int i = 0; i < 8; i++) begin
            rd_en   = 1'b1;
            rd_addr = 4'(i);
            step();
            check($sformatf("seq_read[%0d]", i), data_out, 8'(8'hA0 + i));
            check($sformatf("seq_valid[%0d]", i), {7'd0, rd_valid}, 8'h01);
        end

        // Hold: read addr 3, then idle while rd_addr moves.
        rd_addr = 4'd3;
        step();
        check("hold_first", data_out, 8'hA3);
        rd_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rd_addr = 4'(i + 7);
            step();
            check($sformatf("hold_data[%0d]", i), data_out, 8'hA3);
            check($sformatf("hold_valid[%0d]", i), {7'd0, rd_valid}, 8'h00);
        end

        // Collision on addr 5: write-first.
        wr_en   = 1'b1;
        wr_addr = 4'd5;
        wr_data = 8'h5A;
        rd_en   = 1'b1;
        rd_addr = 4'd5;
        step();
        check("collision_data", data_out, 8'h5A);
        check("collision_valid", {7'd0, rd_valid}, 8'h01);
        wr_en = 1'b0;
        step();
        check("collision_reread", data_out, 8'h5A);

        // Concurrent write addr 9 and read addr 2.
        wr_en   = 1'b1;
        wr_addr = 4'd9;
        wr_data = 8'h99;
        rd_addr = 4'd2;
        step();
        check("concurrent_read", data_out, 8'hA2);
        wr_en   = 1'b0;
        rd_addr = 4'd9;
        step();
        check("concurrent_reread", data_out, 8'h99);

        // Async reset between edges, with a write pending across the reset edge.
        rd_en = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_data", data_out, 8'h00);
        check("async_rst_valid", {7'd0, rd_valid}, 8'h00);
        wr_en   = 1'b1;
        wr_addr = 4'd1;
        wr_data = 8'hFF;
        step();
        rst   = 1'b0;
        wr_en = 1'b0;

        for (int i = 0; i < 8; i++) begin
            rd_en   = 1'b1;
            rd_addr = 4'(i);
            step();
            check($sformatf("post_rst_read[%0d]", i), data_out, 8'h00);
        end
        rd_addr = 4'd9;
        step();
        check("post_rst_read9", data_out, 8'h00);
        rd_en = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
